// File: rtl/opl_small_fallthrough_fifo.sv
// rtl/opl_small_fallthrough_fifo.sv - first-word-fall-through beat FIFO for the output-port-lookup stage
//
// Buffers one AXI-Stream beat per entry, packed as {tlast, tuser, tstrb, tdata}.
// The head entry is always presented on dout while empty is low; rd_en pops it.
// Upstream should drive tready from ~nearly_full so one slot stays free for an in-flight beat.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high; discards all stored entries
//   din          write data (one packed beat)
//   wr_en        write request, dropped while full
//   rd_en        pop request, ignored while empty
//   dout         head-of-queue data, qualified by ~empty
//   full         occupancy == DEPTH
//   nearly_full  occupancy >= DEPTH-1
//   prog_full    occupancy >= PROG_FULL_THRESHOLD
//   empty        occupancy == 0

module opl_small_fallthrough_fifo #(
  parameter int WIDTH               = 417,
  parameter int MAX_DEPTH_BITS      = 2,
  parameter int PROG_FULL_THRESHOLD = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int DEPTH    = 1 << MAX_DEPTH_BITS;
  localparam int CNT_BITS = MAX_DEPTH_BITS + 1;

  localparam logic [CNT_BITS-1:0] CNT_FULL        = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_NEARLY_FULL = CNT_BITS'(DEPTH - 1);
  localparam logic [CNT_BITS-1:0] CNT_PROG_FULL   = CNT_BITS'(PROG_FULL_THRESHOLD);
  localparam logic [CNT_BITS-1:0] CNT_ONE         = CNT_BITS'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = MAX_DEPTH_BITS'(1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0]       count;

  logic wr_acc;
  logic rd_acc;

  // Acceptance is judged against the registered flags, so a write while full
  // is rejected even when a pop happens on the same edge.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Flags decode straight from the count register so they are one gate
  // level from flops and never glitch on input activity.
  assign empty       = (count == '0);
  assign full        = (count == CNT_FULL);
  assign nearly_full = (count >= CNT_NEARLY_FULL);
  assign prog_full   = (count >= CNT_PROG_FULL);

  // Fall-through read: the head entry is visible without a read cycle, and a
  // write into an empty FIFO only shows up after its edge (no bypass path).
  assign dout = mem[rd_ptr];

endmodule

// File: tb/tb_opl_small_fallthrough_fifo.sv
// tb/tb_opl_small_fallthrough_fifo.sv - scoreboard testbench for opl_small_fallthrough_fifo

module tb_opl_small_fallthrough_fifo;

  localparam int WIDTH = 417;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             nearly_full;
  logic             prog_full;
  logic             empty;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb_q [$];

  opl_small_fallthrough_fifo #(
    .WIDTH              (WIDTH),
    .MAX_DEPTH_BITS     (2),
    .PROG_FULL_THRESHOLD(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .nearly_full(nearly_full),
    .prog_full  (prog_full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check the popped head just
  // before the rising edge, update the model, then check flags and head after it.
  task automatic do_cycle(input bit wr, input logic [WIDTH-1:0] d, input bit rd, input bit rst);
    bit wr_acc;
    bit rd_acc;
    int sz;
    wr_en = wr;
    din   = d;
    rd_en = rd;
    reset = rst;
    #1;
    sz     = sb_q.size();
    wr_acc = wr && (sz < DEPTH);
    rd_acc = rd && (sz > 0);
    if (!rst && rd_acc) begin
      check("pop_data", dout, sb_q[0]);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (rd_acc) void'(sb_q.pop_front());
      if (wr_acc) sb_q.push_back(d);
    end
    sz = sb_q.size();
    check("empty",       WIDTH'(empty),       WIDTH'(sz == 0));
    check("full",        WIDTH'(full),        WIDTH'(sz == DEPTH));
    check("nearly_full", WIDTH'(nearly_full), WIDTH'(sz >= DEPTH - 1));
    check("prog_full",   WIDTH'(prog_full),   WIDTH'(sz >= 3));
    if (sz > 0) begin
      check("head", dout, sb_q[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    @(negedge clk);
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    do_cycle(1'b0, '0, 1'b0, 1'b1);

    // Idle after reset.
    for (int i = 0; i < 10; i++) do_cycle(1'b0, '0, 1'b0, 1'b0);

    // Fill to full, overflow write, then drain.
    for (int i = 1; i <= 5; i++) do_cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check("full_after_fill", WIDTH'(full), WIDTH'(1));
    for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("empty_after_drain", WIDTH'(empty), WIDTH'(1));

    // Streaming at a steady occupancy of 2.
    do_cycle(1'b1, WIDTH'(32'h100), 1'b0, 1'b0);
    do_cycle(1'b1, WIDTH'(32'h101), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) do_cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);

    // Wrap-around fill/drain rounds with wide, distinct patterns.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        do_cycle(1'b1, {WIDTH'(r * 16 + i + 32'h55), 64'hdead_beef_0000_0000} ^ (WIDTH'(1) << (WIDTH - 1 - i)),
                 1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    end

    // Abuse: pops while empty, writes while full (also with a same-cycle pop).
    for (int i = 0; i < 3; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, WIDTH'(32'h200 + i), 1'b0, 1'b0);
    do_cycle(1'b1, WIDTH'(32'hbad0), 1'b0, 1'b0);
    do_cycle(1'b1, WIDTH'(32'hbad1), 1'b1, 1'b0);
    do_cycle(1'b1, WIDTH'(32'h300), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset while holding three entries.
    for (int i = 0; i < 3; i++) do_cycle(1'b1, WIDTH'(32'h400 + i), 1'b0, 1'b0);
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    check("rst_empty", WIDTH'(empty), WIDTH'(1));
    check("rst_nearly_full", WIDTH'(nearly_full), WIDTH'(0));
    do_cycle(1'b1, WIDTH'(32'ha), 1'b0, 1'b0);
    check("first_after_rst", dout, WIDTH'(32'ha));
    do_cycle(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
